line_read_scheduler: RTL and testbench
======================================

LINE_READ_SCHEDULER -- requirements
Module: line_read_scheduler

Interface
REQ-001 Parameter LINE_WORDS, default 1280, meaning 16-bit words per line held in one bank of the line RAM.
REQ-002 Parameter ADDR_W, default 11, meaning in-bank address width; LINE_WORDS SHALL be <= 2**ADDR_W.
REQ-003 Parameter GAP_CYCLES, default 16, meaning idle cycles inserted after each read line (blanking), >= 1.
REQ-004 Parameter RD_LATENCY, default 1, meaning line-RAM read latency in clocks, 1..3.
REQ-005 i_clk  input  1  single clock; all logic on rising edge.
REQ-006 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-007 i_frame_start  input  1  one-cycle pulse at camera frame start; synchronous clear.
REQ-008 CAM_En  input  1  camera pixel write strobe; one word written per cycle high.
REQ-009 i_rd_ready  input  1  HDMI side accepts a read issue this cycle.
REQ-010 WR_ADDR  output  ADDR_W+1  line-RAM write address, MSB = write bank, LSBs = word index.
REQ-011 RD_ADDR  output  ADDR_W+1  line-RAM read address, MSB = read bank, LSBs = word index.
REQ-012 o_rd_valid  output  1  RAM q carries valid pixel this cycle.
REQ-013 o_line_start  output  1  one-cycle pulse when a line read begins.
REQ-014 o_line_done  output  1  one-cycle pulse on the cycle the last word of a line is valid at q.
REQ-015 o_overflow  output  1  sticky: a completed camera line was dropped.
REQ-016 o_lines_ready  output  2  complete, unread lines buffered (0..2).

Function
REQ-017 Write counter: on CAM_En, index increments; at LINE_WORDS-1 it wraps to 0 and the line completes.
REQ-018 Line complete with o_lines_ready < 2: write bank toggles, o_lines_ready +1.
REQ-019 Line complete with o_lines_ready == 2: write bank unchanged (line overwritten), count unchanged, o_overflow set.
REQ-020 Read FSM states: IDLE, START, READ, DRAIN, GAP.
REQ-021 IDLE -> START when o_lines_ready > 0; START lasts exactly 1 cycle, asserts o_line_start, read index = 0.
REQ-022 START -> READ; in READ an issue occurs each cycle i_rd_ready is high; RD_ADDR index increments per issue; i_rd_ready low holds RD_ADDR.
REQ-023 Issue of index LINE_WORDS-1: READ -> DRAIN, read bank toggles, o_lines_ready -1 on that cycle.
REQ-024 o_rd_valid = issue delayed exactly RD_LATENCY cycles; o_line_done coincides with o_rd_valid of last word.
REQ-025 DRAIN holds RD_LATENCY cycles, then GAP; GAP holds GAP_CYCLES cycles, then IDLE.
REQ-026 Simultaneous write line-complete and read last-issue: o_lines_ready unchanged, both banks toggle, no overflow.
REQ-027 Write bank and read bank SHALL never both address the bank being read while o_lines_ready > 0 (no read/write collision).
REQ-028 i_frame_start: write index, read index, both bank bits, o_lines_ready, delay pipe, o_overflow cleared; FSM -> IDLE; a concurrent CAM_En write is to index 0 bank 0 and counts as first word.
REQ-029 Index arithmetic is ADDR_W bits, never exceeds LINE_WORDS-1; o_lines_ready saturates at 0 and 2.

Reset
REQ-030 While i_rst_n low: WR_ADDR=0, RD_ADDR=0, o_rd_valid=0, o_line_start=0, o_line_done=0, o_overflow=0, o_lines_ready=0, FSM=IDLE, delay pipe cleared.
REQ-031 Reset assertion mid-line aborts immediately; first edge after deassertion behaves as idle from state of REQ-030.

Verification
REQ-032 LINE_WORDS=8, 8 CAM_En pulses, i_rd_ready=1 -> o_lines_ready 1, START pulse, RD_ADDR 0..7 bank 0, o_rd_valid 8 cycles lagging RD_LATENCY, o_line_done on 8th, bank 1 next.
REQ-033 Three lines written, no reads (i_rd_ready=0 held but FSM blocks in READ) -> o_lines_ready=2, o_overflow=1 after third line, WR_ADDR MSB unchanged on third completion.
REQ-034 i_rd_ready toggling 1/0 during READ -> RD_ADDR advances only on high cycles, o_rd_valid pattern equals delayed ready pattern, 8 valid total.
REQ-035 Write completion and read last-issue same cycle with o_lines_ready=1 -> stays 1, no overflow, both bank bits flip.
REQ-036 i_frame_start mid-READ with o_overflow=1 -> all counters 0, o_overflow=0, FSM IDLE, no o_line_done.
REQ-037 i_rst_n low for 1 cycle mid-READ -> outputs per REQ-030 asynchronously, resumes correctly on new lines.

Source files
------------

// File: rtl/line_read_scheduler.sv
// rtl/line_read_scheduler.sv - double-banked line RAM write/read address scheduler
module line_read_scheduler #(
  parameter int LINE_WORDS = 1280,
  parameter int ADDR_W     = 11,
  parameter int GAP_CYCLES = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              CAM_En,
  input  logic              i_rd_ready,
  output logic [ADDR_W:0]   WR_ADDR,
  output logic [ADDR_W:0]   RD_ADDR,
  output logic              o_rd_valid,
  output logic              o_line_start,
  output logic              o_line_done,
  output logic              o_overflow,
  output logic [1:0]        o_lines_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LINE_WORDS - 1);
  localparam int CNT_W = $clog2(GAP_CYCLES + RD_LATENCY + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_READ, S_DRAIN, S_GAP} state_t;

  state_t                  state;
  logic [ADDR_W-1:0]       wr_idx;
  logic                    wr_bank;
  logic [ADDR_W-1:0]       rd_idx;
  logic                    rd_bank;
  logic [CNT_W-1:0]        cnt;
  logic [RD_LATENCY-1:0]   valid_pipe;
  logic [RD_LATENCY-1:0]   done_pipe;

  // Frame start makes this cycle behave as if the counters were already cleared
  logic [ADDR_W-1:0]       cur_wr_idx;
  logic                    cur_wr_bank;
  logic [1:0]              cur_lines;
  logic                    rd_issue;
  logic                    rd_last;
  logic                    wr_last;
  logic                    accept;
  logic [1:0]              lines_next;

  assign WR_ADDR    = {cur_wr_bank, cur_wr_idx};
  assign RD_ADDR    = {rd_bank, rd_idx};
  assign o_rd_valid = valid_pipe[RD_LATENCY-1];
  assign o_line_done = done_pipe[RD_LATENCY-1];

  // Decode this cycle's write completion, read issue and buffered-line update
  always_comb begin
    cur_wr_idx  = i_frame_start ? '0 : wr_idx;
    cur_wr_bank = i_frame_start ? 1'b0 : wr_bank;
    cur_lines   = i_frame_start ? 2'd0 : o_lines_ready;
    rd_issue    = (state == S_READ) && i_rd_ready && !i_frame_start;
    rd_last     = rd_issue && (rd_idx == LAST_IDX);
    wr_last     = CAM_En && (cur_wr_idx == LAST_IDX);
    // A full buffer only accepts a new line when a read is releasing a bank now
    accept      = wr_last && ((cur_lines != 2'd2) || rd_last);
    lines_next  = cur_lines;
    if (accept && !rd_last && cur_lines != 2'd2) begin
      lines_next = cur_lines + 2'd1;
    end else if (!accept && rd_last && cur_lines != 2'd0) begin
      lines_next = cur_lines - 2'd1;
    end
  end

  // Camera write index, write bank and sticky overflow
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_idx     <= '0;
      wr_bank    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (CAM_En) begin
        wr_idx <= wr_last ? '0 : cur_wr_idx + ADDR_W'(1);
      end else begin
        wr_idx <= cur_wr_idx;
      end
      wr_bank    <= cur_wr_bank ^ accept;
      o_overflow <= (o_overflow && !i_frame_start) || (wr_last && !accept);
    end
  end

  // Count of complete, unread lines
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lines_ready <= 2'd0;
    end else begin
      o_lines_ready <= lines_next;
    end
  end

  // Read sequencer: start pulse, word issue, latency drain and blanking gap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      rd_idx       <= '0;
      rd_bank      <= 1'b0;
      cnt          <= '0;
      o_line_start <= 1'b0;
    end else if (i_frame_start) begin
      state        <= S_IDLE;
      rd_idx       <= '0;
      rd_bank      <= 1'b0;
      cnt          <= '0;
      o_line_start <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (o_lines_ready != 2'd0) begin
            state        <= S_START;
            o_line_start <= 1'b1;
            rd_idx       <= '0;
          end
        end
        S_START: begin
          o_line_start <= 1'b0;
          state        <= S_READ;
        end
        S_READ: begin
          if (i_rd_ready) begin
            if (rd_idx == LAST_IDX) begin
              rd_idx  <= '0;
              rd_bank <= ~rd_bank;
              cnt     <= CNT_W'(RD_LATENCY - 1);
              state   <= S_DRAIN;
            end else begin
              rd_idx <= rd_idx + ADDR_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (cnt == '0) begin
            cnt   <= CNT_W'(GAP_CYCLES - 1);
            state <= S_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay issue and last-word flags to line up with RAM output data
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_pipe <= '0;
      done_pipe  <= '0;
    end else if (i_frame_start) begin
      valid_pipe <= '0;
      done_pipe  <= '0;
    end else begin
      valid_pipe[0] <= rd_issue;
      done_pipe[0]  <= rd_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        done_pipe[i]  <= done_pipe[i-1];
      end
    end
  end

endmodule

// File: tb/tb_line_read_scheduler.sv
// tb/tb_line_read_scheduler.sv - randomized bench with behavioural line buffer model
module tb_line_read_scheduler;

  localparam int LW  = 8;
  localparam int AW  = 3;
  localparam int GAP = 3;
  localparam int LAT = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_frame_start = 1'b0;
  logic          CAM_En = 1'b0;
  logic          i_rd_ready = 1'b0;
  logic [AW:0]   WR_ADDR;
  logic [AW:0]   RD_ADDR;
  logic          o_rd_valid;
  logic          o_line_start;
  logic          o_line_done;
  logic          o_overflow;
  logic [1:0]    o_lines_ready;

  line_read_scheduler #(
    .LINE_WORDS(LW), .ADDR_W(AW), .GAP_CYCLES(GAP), .RD_LATENCY(LAT)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .CAM_En(CAM_En), .i_rd_ready(i_rd_ready), .WR_ADDR(WR_ADDR), .RD_ADDR(RD_ADDR),
    .o_rd_valid(o_rd_valid), .o_line_start(o_line_start), .o_line_done(o_line_done),
    .o_overflow(o_overflow), .o_lines_ready(o_lines_ready)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model: buffer occupancy plus a reader described by intent, not encoding
  int m_wr_idx, m_wr_bank, m_lines, m_ovf;
  int m_rd_idx, m_rd_bank, m_tail;
  bit m_reading, m_start_pending;
  typedef struct { int due; bit last; } vev_t;
  vev_t vq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    vq.delete();
    m_wr_idx = 0; m_wr_bank = 0; m_lines = 0; m_ovf = 0;
    m_rd_idx = 0; m_rd_bank = 0; m_tail = 0;
    m_reading = 0; m_start_pending = 0;
  endtask

  task automatic model_step(input bit cam, input bit fs, input bit rdy);
    bit issue, is_last, complete, accept;
    int old_lines;
    if (fs) begin
      model_reset();
      m_wr_idx = cam ? 1 : 0;
      return;
    end
    issue    = m_reading && rdy;
    is_last  = issue && (m_rd_idx == LW - 1);
    complete = cam && (m_wr_idx == LW - 1);
    accept   = complete && (m_lines < 2 || is_last);
    old_lines = m_lines;
    if (cam) m_wr_idx = complete ? 0 : m_wr_idx + 1;
    if (accept) m_wr_bank ^= 1;
    if (complete && !accept) m_ovf = 1;
    m_lines = m_lines + int'(accept) - int'(is_last);
    if (m_start_pending) begin
      m_start_pending = 0;
      m_reading = 1;
      m_rd_idx = 0;
    end else if (m_reading) begin
      if (issue) begin
        vq.push_back('{due: cyc + LAT, last: is_last});
        if (is_last) begin
          m_reading = 0;
          m_rd_bank ^= 1;
          m_rd_idx = 0;
          m_tail = LAT + GAP;
        end else begin
          m_rd_idx++;
        end
      end
    end else if (m_tail > 0) begin
      m_tail--;
    end else if (old_lines > 0) begin
      m_start_pending = 1;
    end
  endtask

  // One clock: drive inputs at the falling edge, compare, then advance the model
  task automatic cycle(input bit cam, input bit fs, input bit rdy);
    bit ev, ed;
    CAM_En = cam; i_frame_start = fs; i_rd_ready = rdy;
    #1;
    while (vq.size() > 0 && vq[0].due < cyc) void'(vq.pop_front());
    ev = 0; ed = 0;
    if (vq.size() > 0 && vq[0].due == cyc) begin ev = 1; ed = vq[0].last; end
    check("wr_addr", WR_ADDR, fs ? 0 : m_wr_bank * LW + m_wr_idx);
    check("rd_addr", RD_ADDR, m_rd_bank * LW + m_rd_idx);
    check("rd_valid", o_rd_valid, ev);
    check("line_done", o_line_done, ed);
    check("line_start", o_line_start, m_start_pending);
    check("overflow", o_overflow, m_ovf);
    check("lines_ready", o_lines_ready, m_lines);
    @(posedge i_clk);
    model_step(cam, fs, rdy);
    cyc++;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; CAM_En = 0; i_frame_start = 0; i_rd_ready = 0;
    #1;
    check("rst_wr_addr", WR_ADDR, 0);
    check("rst_rd_addr", RD_ADDR, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_line_start", o_line_start, 0);
    check("rst_line_done", o_line_done, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_lines_ready", o_lines_ready, 0);
    model_reset();
    @(posedge i_clk);
    cyc++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    int n;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // One line, reader always ready
    for (int i = 0; i < LW; i++) cycle(1, 0, 1);
    for (int i = 0; i < LW + LAT + GAP + 6; i++) cycle(0, 0, 1);

    // Three lines with reader stalled: overflow on the third
    for (int i = 0; i < 3 * LW; i++) cycle(1, 0, 0);
    check("ovf_lines", o_lines_ready, 2);
    check("ovf_flag", o_overflow, 1);
    // Ready toggling during the stalled read, then frame start mid-line
    for (int i = 0; i < 5; i++) cycle(0, 0, i[0]);
    cycle(0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);

    // Ready toggling 1/0 over a whole line
    for (int i = 0; i < LW; i++) cycle(1, 0, 0);
    for (int i = 0; i < 2 * LW + LAT + GAP + 6; i++) cycle(0, 0, i[0]);

    // Write completion coinciding with the last read issue
    for (int i = 0; i < LW; i++) cycle(1, 0, 1);
    n = 0;
    while (!m_start_pending && n < 40) begin cycle(0, 0, 1); n++; end
    check("wait_start", n < 40, 1);
    cycle(0, 0, 1);
    for (int i = 0; i < LW; i++) cycle(1, 0, 1);
    check("coincide_lines", o_lines_ready, 1);
    for (int i = 0; i < 2 * LW + 2 * (LAT + GAP) + 6; i++) cycle(0, 0, 1);

    // Reset mid-read, then recovery on new lines
    for (int i = 0; i < LW; i++) cycle(1, 0, 1);
    n = 0;
    while (!(m_reading && m_rd_idx > 2) && n < 40) begin cycle(0, 0, 1); n++; end
    check("wait_read", n < 40, 1);
    do_reset();
    for (int i = 0; i < 2 * LW; i++) cycle(1, 0, 1);
    for (int i = 0; i < 3 * LW; i++) cycle(0, 0, $urandom_range(0, 99) < 70);

    // Randomized traffic with varying write/read pressure and rare frame starts
    for (int p = 0; p < 4; p++) begin
      int pc, pr;
      pc = (p == 0) ? 100 : (p == 1) ? 80 : (p == 2) ? 50 : 95;
      pr = (p == 0) ? 100 : (p == 1) ? 40 : (p == 2) ? 90 : 60;
      for (int i = 0; i < 400; i++)
        cycle($urandom_range(0, 99) < pc, $urandom_range(0, 299) == 0,
              $urandom_range(0, 99) < pr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
